// File: rtl/redpi_pll_ctrl.sv
// PLL bring-up controller: sequences PLL reset/power-down, qualifies the lock flag,
// and releases the downstream active-low reset only after lock has been stable.
module redpi_pll_ctrl #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned LOST_W        = 8
) (
  input  logic              clk_in,
  input  logic              rstn,
  input  logic              pll_locked,
  input  logic              pd_req,
  input  logic              retry_req,
  output logic              pll_reset,
  output logic              pll_pwrdn,
  output logic              sys_rstn,
  output logic              lock_ok,
  output logic              fail,
  output logic [7:0]        retry_cnt,
  output logic [LOST_W-1:0] lost_cnt,
  output logic [2:0]        state_o
);

  localparam int unsigned MAXC_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAXC   = (MAXC_A > STABLE_CYCLES) ? MAXC_A : STABLE_CYCLES;
  localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0]     RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]     LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]     STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE     = CW'(1);
  localparam logic [7:0]        RETRY_MAX   = 8'(MAX_RETRY);
  localparam logic [LOST_W-1:0] LOST_ONE    = LOST_W'(1);

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4,
    S_PD        = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [7:0]        retry_nx, retry_inc;
  logic [LOST_W-1:0] lost_nx;
  logic              lock_meta, locked_s;
  logic              pll_reset_nx, pll_pwrdn_nx, run_nx, fail_nx;

  assign state_o = state;

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
      state     <= S_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
      pll_reset <= 1'b1;
      pll_pwrdn <= 1'b0;
      sys_rstn  <= 1'b0;
      lock_ok   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry_cnt <= retry_nx;
      lost_cnt  <= lost_nx;
      pll_reset <= pll_reset_nx;
      pll_pwrdn <= pll_pwrdn_nx;
      sys_rstn  <= run_nx;
      lock_ok   <= run_nx;
      fail      <= fail_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    retry_nx  = retry_cnt;
    lost_nx   = lost_cnt;
    retry_inc = retry_cnt + 8'd1;

    // Power-down pre-empts every other transition, including timeout or loss.
    if (pd_req) begin
      state_nx = S_PD;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        S_RST: begin
          if (cnt == RST_LAST) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nx = S_STABLE;
            cnt_nx   = '0;
          end else if (cnt == LOCK_LAST) begin
            retry_nx = retry_inc;
            cnt_nx   = '0;
            state_nx = (retry_inc == RETRY_MAX) ? S_FAIL : S_RST;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
            retry_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nx = S_RST;
            cnt_nx   = '0;
            if (lost_cnt != '1) lost_nx = lost_cnt + LOST_ONE;
          end
        end
        S_FAIL: begin
          if (retry_req) begin
            state_nx = S_RST;
            cnt_nx   = '0;
            retry_nx = '0;
          end
        end
        S_PD: begin
          state_nx = S_RST;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = S_RST;
          cnt_nx   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they move with the state register.
    pll_reset_nx = (state_nx == S_RST) || (state_nx == S_FAIL) || (state_nx == S_PD);
    pll_pwrdn_nx = (state_nx == S_PD);
    run_nx       = (state_nx == S_RUN);
    fail_nx      = (state_nx == S_FAIL);
  end

endmodule
